// File: rtl/object_renderer_pkg.sv
// Shared game definitions: sprite geometry, object word layout, sprite colour data.
// Used by object_renderer and game_logic so both agree on the object format.
// The sprite contents are a generator function so the ROM has a known image.
package object_renderer_pkg;

  localparam int GAME_OBJ_WIDTH  = 20;
  localparam int GAME_OBJ_HEIGHT = 20;

  // Object word: [25:23] frame, [22:21] identity, [20:10] hpos, [9:0] vpos
  localparam int FRAME_HI = 25;
  localparam int FRAME_LO = 23;
  localparam int ID_HI    = 22;
  localparam int ID_LO    = 21;
  localparam int HPOS_HI  = 20;
  localparam int HPOS_LO  = 10;
  localparam int VPOS_HI  = 9;
  localparam int VPOS_LO  = 0;

  localparam logic [11:0] TRANSPARENT = 12'h000;

  typedef logic [25:0] obj_word_t;

  // Sprite image keyed by {identity, frame, row, col}. Column 7 of every
  // sprite is transparent; every other pixel is nonzero (low bits 2'b01).
  function automatic logic [11:0] sprite_color(input logic [14:0] addr);
    logic [11:0] c;
    c = {addr[14:13] ^ addr[9:8], addr[12:10] ^ addr[7:5], addr[4:0], 2'b01};
    if (addr[4:0] == 5'd7) c = TRANSPARENT;
    return c;
  endfunction

endpackage

// File: rtl/object_renderer_sprite_rom.sv
// Sprite colour ROM, 32768 x 12, addressed by {identity, frame, row, col}.
// Latency: one cycle from address to data (registered read).
// No backpressure: a new address is accepted every cycle.
module sprite_rom
  import object_renderer_pkg::*;
(
  input  logic        clock,
  input  logic [14:0] addr,
  output logic [11:0] data
);

  // Registered read of the sprite image
  always_ff @(posedge clock) begin
    data <= sprite_color(addr);
  end

endmodule

// File: rtl/object_renderer.sv
// Composites up to five sprites over the background for a VGA pixel stream.
// Latency: pixel_out and timing outputs are exactly 3 cycles after the inputs.
// No backpressure: one pixel in and one pixel out every cycle, never stalls.
module object_renderer
  import object_renderer_pkg::*;
#(
  parameter int OBJ_WIDTH  = GAME_OBJ_WIDTH,
  parameter int OBJ_HEIGHT = GAME_OBJ_HEIGHT,
  parameter int LATENCY    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank,
  input  logic [25:0] p_obj1,
  input  logic [25:0] p_obj2,
  input  logic [25:0] p_obj3,
  input  logic [25:0] p_obj4,
  input  logic [25:0] p_obj5,
  input  logic [11:0] bg_pixel,
  output logic [11:0] pixel_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out
);

  obj_word_t objs   [5];
  obj_word_t shadow [5];
  logic      vsync_d;

  assign objs[0] = p_obj1;
  assign objs[1] = p_obj2;
  assign objs[2] = p_obj3;
  assign objs[3] = p_obj4;
  assign objs[4] = p_obj5;

  // Latch object words only at frame start so a frame never tears
  always_ff @(posedge clock) begin
    if (reset) begin
      vsync_d <= 1'b0;
      for (int k = 0; k < 5; k++) shadow[k] <= '0;
    end else begin
      vsync_d <= vsync;
      if (vsync && !vsync_d) begin
        for (int k = 0; k < 5; k++) shadow[k] <= objs[k];
      end
    end
  end

  // Stage-1 hit test per object; compares are one bit wider than the
  // operands so hpos+OBJ_WIDTH past the right edge cannot wrap to column 0.
  logic [11:0] hc_w;
  logic [10:0] vc_w;
  logic [4:0]  obj_hit;
  logic [14:0] obj_addr [5];

  assign hc_w = {1'b0, hcount};
  assign vc_w = {1'b0, vcount};

  for (genvar k = 0; k < 5; k++) begin : g_obj
    logic [11:0] hp_w;
    logic [10:0] vp_w;
    logic [4:0]  col;
    logic [4:0]  row;

    assign hp_w = {1'b0, shadow[k][HPOS_HI:HPOS_LO]};
    assign vp_w = {1'b0, shadow[k][VPOS_HI:VPOS_LO]};
    // Only the low five bits of the offsets address the sprite
    assign col  = hcount[4:0] - shadow[k][HPOS_LO+4:HPOS_LO];
    assign row  = vcount[4:0] - shadow[k][VPOS_LO+4:VPOS_LO];

    assign obj_hit[k] = (shadow[k] != '0) &&
                        (hc_w >= hp_w) && (hc_w < hp_w + 12'(OBJ_WIDTH)) &&
                        (vc_w >= vp_w) && (vc_w < vp_w + 11'(OBJ_HEIGHT));
    assign obj_addr[k] = {shadow[k][ID_HI:ID_LO], shadow[k][FRAME_HI:FRAME_LO], row, col};
  end

  logic        win_hit;
  logic [14:0] win_addr;

  // Priority select: scanning from obj5 down lets the lowest index win
  always_comb begin
    win_hit  = 1'b0;
    win_addr = '0;
    for (int k = 4; k >= 0; k--) begin
      if (obj_hit[k]) begin
        win_hit  = 1'b1;
        win_addr = obj_addr[k];
      end
    end
  end

  logic        s1_hit;
  logic [14:0] s1_addr;
  logic [11:0] bg_d1;

  // Stage 1: register the winning object's hit flag, ROM address and background
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_hit  <= 1'b0;
      s1_addr <= '0;
      bg_d1   <= '0;
    end else begin
      s1_hit  <= win_hit;
      s1_addr <= win_addr;
      bg_d1   <= bg_pixel;
    end
  end

  logic [11:0] rom_data;

  sprite_rom u_sprite_rom (
    .clock (clock),
    .addr  (s1_addr),
    .data  (rom_data)
  );

  logic        s2_hit;
  logic [11:0] bg_d2;

  // Stage 2: carry hit flag and background alongside the ROM read
  always_ff @(posedge clock) begin
    if (reset) begin
      s2_hit <= 1'b0;
      bg_d2  <= '0;
    end else begin
      s2_hit <= s1_hit;
      bg_d2  <= bg_d1;
    end
  end

  logic [LATENCY-1:0] hs_pipe;
  logic [LATENCY-1:0] vs_pipe;
  logic [LATENCY-1:0] bl_pipe;

  // Timing delay lines; reset fills them with the idle level (all high)
  always_ff @(posedge clock) begin
    if (reset) begin
      hs_pipe <= '1;
      vs_pipe <= '1;
      bl_pipe <= '1;
    end else begin
      hs_pipe <= {hs_pipe[LATENCY-2:0], hsync};
      vs_pipe <= {vs_pipe[LATENCY-2:0], vsync};
      bl_pipe <= {bl_pipe[LATENCY-2:0], blank};
    end
  end

  assign hsync_out = hs_pipe[LATENCY-1];
  assign vsync_out = vs_pipe[LATENCY-1];
  assign blank_out = bl_pipe[LATENCY-1];

  // Stage 3: blanking forces black; a transparent winner shows background
  always_ff @(posedge clock) begin
    if (reset) begin
      pixel_out <= '0;
    end else if (bl_pipe[1]) begin
      pixel_out <= '0;
    end else if (s2_hit && rom_data != TRANSPARENT) begin
      pixel_out <= rom_data;
    end else begin
      pixel_out <= bg_d2;
    end
  end

endmodule

// File: tb/tb_object_renderer.sv
// Scoreboard bench for object_renderer: stimulus queues expected outputs,
// a negedge monitor compares them when their cycle comes due.
module tb_object_renderer;

  logic        clock = 1'b0;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync, vsync, blank;
  logic [25:0] p_obj1, p_obj2, p_obj3, p_obj4, p_obj5;
  logic [11:0] bg_pixel;
  logic [11:0] pixel_out;
  logic        hsync_out, vsync_out, blank_out;

  always #5 clock = ~clock;

  object_renderer dut (
    .clock     (clock),
    .reset     (reset),
    .hcount    (hcount),
    .vcount    (vcount),
    .hsync     (hsync),
    .vsync     (vsync),
    .blank     (blank),
    .p_obj1    (p_obj1),
    .p_obj2    (p_obj2),
    .p_obj3    (p_obj3),
    .p_obj4    (p_obj4),
    .p_obj5    (p_obj5),
    .bg_pixel  (bg_pixel),
    .pixel_out (pixel_out),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .blank_out (blank_out)
  );

  typedef struct {
    int          due;
    logic [11:0] pix;
    logic        hs;
    logic        vs;
    logic        bl;
    string       tag;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  string       cur_tag = "reset";
  logic [25:0] m_sh [5];
  bit          m_vs_prev = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference sprite image: column 7 transparent, otherwise
  // {id ^ row[4:3], frame ^ row[2:0], col, 01}.
  function automatic logic [11:0] rom_model(input int id, input int fr, input int row, input int col);
    logic [1:0] idx;
    logic [2:0] frx;
    if (col == 7) return 12'h000;
    idx = 2'(id) ^ 2'(row >> 3);
    frx = 3'(fr) ^ 3'(row);
    return {idx, frx, 5'(col), 2'b01};
  endfunction

  function automatic logic [11:0] model_pix(input int h, input int v, input bit blk, input logic [11:0] bg);
    int hp, vp, id, fr;
    logic [11:0] c;
    if (blk) return 12'h000;
    for (int k = 0; k < 5; k++) begin
      hp = int'(m_sh[k][20:10]);
      vp = int'(m_sh[k][9:0]);
      id = int'(m_sh[k][22:21]);
      fr = int'(m_sh[k][25:23]);
      if (m_sh[k] != 26'd0 && h >= hp && h < hp + 20 && v >= vp && v < vp + 20) begin
        c = rom_model(id, fr, v - vp, h - hp);
        return (c != 12'h000) ? c : bg;
      end
    end
    return bg;
  endfunction

  task automatic step(input int h, input int v, input bit vs, input bit blk);
    exp_t e;
    @(negedge clock);
    reset    = 1'b0;
    hcount   = 11'(h);
    vcount   = 10'(v);
    vsync    = vs;
    blank    = blk;
    hsync    = (h % 3 == 0);
    bg_pixel = 12'h800 | 12'(h & 255);
    e.due = cyc + 3;
    e.pix = model_pix(h, v, blk, bg_pixel);
    e.hs  = hsync;
    e.vs  = vs;
    e.bl  = blk;
    e.tag = cur_tag;
    q.push_back(e);
    if (vs && !m_vs_prev) m_sh = '{p_obj1, p_obj2, p_obj3, p_obj4, p_obj5};
    m_vs_prev = vs;
  endtask

  task automatic vsync_pulse();
    step(0, 0, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b0);
  endtask

  task automatic scan(input int v, input int h0, input int h1, input bit blk);
    for (int h = h0; h <= h1; h++) step(h, v, 1'b0, blk);
  endtask

  // Reset for n cycles; pending pixels are discarded and the outputs show the
  // reset level until the pipeline refills two cycles after release.
  task automatic do_reset(input int n);
    exp_t e;
    exp_t keep[$];
    @(negedge clock);
    reset = 1'b1;
    foreach (q[i]) if (q[i].due <= cyc) keep.push_back(q[i]);
    q = keep;
    for (int i = 1; i <= n + 2; i++) begin
      e.due = cyc + i;
      e.pix = 12'h000;
      e.hs  = 1'b1;
      e.vs  = 1'b1;
      e.bl  = 1'b1;
      e.tag = cur_tag;
      q.push_back(e);
    end
    for (int k = 0; k < 5; k++) m_sh[k] = 26'd0;
    m_vs_prev = 1'b0;
    repeat (n - 1) @(negedge clock);
  endtask

  // Monitor: compare every output whose cycle has come due
  always @(negedge clock) begin
    while (q.size() > 0 && q[0].due < cyc) begin
      mon_e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: output due at cycle %0d was never compared", mon_e.tag, mon_e.due);
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      mon_e = q.pop_front();
      checks++;
      if (pixel_out !== mon_e.pix || hsync_out !== mon_e.hs ||
          vsync_out !== mon_e.vs || blank_out !== mon_e.bl) begin
        errors++;
        $display("FAIL %s cyc %0d: got pix=%h hs=%b vs=%b bl=%b, want pix=%h hs=%b vs=%b bl=%b",
                 mon_e.tag, cyc, pixel_out, hsync_out, vsync_out, blank_out,
                 mon_e.pix, mon_e.hs, mon_e.vs, mon_e.bl);
      end
    end
  end

  initial begin
    reset = 1'b1; hcount = '0; vcount = '0; hsync = 1'b0; vsync = 1'b0; blank = 1'b0;
    p_obj1 = '0; p_obj2 = '0; p_obj3 = '0; p_obj4 = '0; p_obj5 = '0; bg_pixel = '0;
    for (int k = 0; k < 5; k++) m_sh[k] = 26'd0;

    cur_tag = "reset";
    do_reset(2);

    // Single object at (100,200): full row scan plus one column either side
    cur_tag = "single_obj";
    p_obj1 = {3'd0, 2'd0, 11'd100, 10'd200};
    vsync_pulse();
    scan(200, 99, 120, 1'b0);
    cur_tag = "single_obj_row3";
    scan(203, 100, 104, 1'b0);

    // Overlap: obj1 wins, its transparent column shows background only
    cur_tag = "priority";
    p_obj1 = {3'd1, 2'd1, 11'd300, 10'd300};
    p_obj2 = {3'd2, 2'd2, 11'd300, 10'd300};
    vsync_pulse();
    scan(305, 298, 322, 1'b0);
    cur_tag = "obj2_after_clear";
    p_obj1 = '0;
    vsync_pulse();
    scan(305, 298, 322, 1'b0);
    p_obj2 = '0;

    // Mid-frame move is ignored until the next vsync rise
    cur_tag = "no_tear";
    p_obj1 = {3'd0, 2'd3, 11'd500, 10'd100};
    vsync_pulse();
    scan(100, 498, 506, 1'b0);
    p_obj1 = {3'd0, 2'd3, 11'd502, 10'd100};
    scan(100, 498, 506, 1'b0);
    cur_tag = "moved_after_vsync";
    vsync_pulse();
    scan(100, 498, 506, 1'b0);

    // Right-edge object and an object at the origin with nonzero identity
    cur_tag = "right_edge";
    p_obj1 = {3'd0, 2'd1, 11'd1015, 10'd50};
    p_obj3 = {3'd0, 2'd1, 11'd0, 10'd0};
    vsync_pulse();
    scan(50, 1010, 1023, 1'b0);
    cur_tag = "no_wrap";
    scan(50, 0, 11, 1'b0);
    cur_tag = "origin_obj";
    scan(5, 0, 8, 1'b0);

    // Blanking over an object
    cur_tag = "blank";
    scan(50, 1015, 1020, 1'b1);
    cur_tag = "unblank";
    scan(50, 1015, 1017, 1'b0);

    // Reset mid-object, then background only until the next vsync rise
    cur_tag = "mid_reset";
    scan(50, 1016, 1018, 1'b0);
    do_reset(1);
    cur_tag = "bg_after_reset";
    scan(50, 1014, 1023, 1'b0);
    cur_tag = "reload_after_reset";
    vsync_pulse();
    scan(50, 1014, 1023, 1'b0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clock);
    #1;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected outputs still pending, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
